// File: rtl/pctl_pkg.sv
// Shared types and field positions for the phase-center table controller.
// The optional clear feature is enabled with PHASE_CENTER_CLEAR_EN.
package pctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_CLEAR     = 2'd2,
    ST_SWAP_WAIT = 2'd3
  } pctl_state_t;

  localparam int CTRL_LOAD_BIT  = 0;
  localparam int CTRL_SWAP_BIT  = 1;
  localparam int CTRL_CLEAR_BIT = 2;

  localparam int STAT_SWAP_PEND   = 0;
  localparam int STAT_ACTIVE_BANK = 1;
  localparam int STAT_BUSY        = 2;
  localparam int STAT_DROP_LSB    = 8;
  localparam int STAT_DROP_W      = 8;
  localparam int STAT_LOAD_LSB    = 16;
  localparam int STAT_LOAD_W      = 16;

  localparam logic [STAT_DROP_W-1:0] DROP_SAT = {STAT_DROP_W{1'b1}};

  // Up to three commands can be dropped in one cycle; the count sticks at DROP_SAT.
  function automatic logic [STAT_DROP_W-1:0] drop_add(input logic [STAT_DROP_W-1:0] cnt,
                                                      input logic [1:0]             inc);
    logic [STAT_DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(STAT_DROP_W-1){1'b0}}, inc};
    return (sum > {1'b0, DROP_SAT}) ? DROP_SAT : sum[STAT_DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pctl_dpram.sv
// Simple dual-port RAM holding both center banks: port A writes, port B reads
// with a registered output. Contents are never reset.
module pctl_dpram #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk) begin
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/phase_center_table_ctrl.sv
// Double-buffered phase-center table: software writes the shadow bank, banks swap on sof.
// Define PHASE_CENTER_CLEAR_EN to include the bulk-clear command and CLEAR state.
module phase_center_table_ctrl
  import pctl_pkg::*;
#(
  parameter int NCH   = 256,
  parameter int NCH_W = 8,
  parameter int CW    = 16
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic [31:0]      cfg_data,
  input  logic [31:0]      cfg_ctrl,
  input  logic             sof,
  input  logic [NCH_W-1:0] ch_idx,
  input  logic             ch_valid,
  output logic [CW-1:0]    center_out,
  output logic             center_valid,
  output logic [31:0]      status
);

  pctl_state_t state, state_nxt;

  logic [2:0]              ctrl_prev;
  logic                    armed;
  logic                    ev_load, ev_swap, ev_clear;
  logic                    pend_load, pend_swap, pend_clear;
  logic                    pend_load_nxt, pend_swap_nxt, pend_clear_nxt;
  logic                    req_load, req_swap, req_clear;
  logic                    take_load, take_swap, take_clear;
  logic                    in_idle;
  logic                    active_bank;
  logic [STAT_DROP_W-1:0]  drop_cnt;
  logic [1:0]              drop_inc;
  logic [STAT_LOAD_W-1:0]  load_cnt;
  logic                    load_inc;
  logic                    swap_now;
  logic                    busy;
  logic                    ram_we;
  logic [NCH_W:0]          ram_waddr;
  logic [CW-1:0]           ram_wdata;
  logic                    rd_bank;
  logic [CW-1:0]           ram_q;
  logic                    rd_valid;
  logic                    unused_cfg;

  // The first cycle out of reset only captures cfg_ctrl, so a bit held high is not an event.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_prev <= '0;
      armed     <= 1'b0;
    end else begin
      ctrl_prev <= cfg_ctrl[2:0];
      armed     <= 1'b1;
    end
  end

  assign ev_load = armed & (cfg_ctrl[CTRL_LOAD_BIT] ^ ctrl_prev[CTRL_LOAD_BIT]);
  assign ev_swap = armed & (cfg_ctrl[CTRL_SWAP_BIT] ^ ctrl_prev[CTRL_SWAP_BIT]);

`ifdef PHASE_CENTER_CLEAR_EN
  logic [NCH_W-1:0] clr_cnt;
  logic             clr_last;

  assign ev_clear   = armed & (cfg_ctrl[CTRL_CLEAR_BIT] ^ ctrl_prev[CTRL_CLEAR_BIT]);
  assign clr_last   = (clr_cnt == NCH_W'(NCH - 1));
  assign unused_cfg = ^{cfg_data[15:NCH_W], cfg_ctrl[31:3]};

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
    end
  end
`else
  assign ev_clear   = 1'b0;
  assign unused_cfg = ^{cfg_data[15:NCH_W], cfg_ctrl[31:2], ctrl_prev[CTRL_CLEAR_BIT]};
`endif

  assign req_load   = ev_load  | pend_load;
  assign req_clear  = ev_clear | pend_clear;
  assign req_swap   = ev_swap  | pend_swap;
  assign in_idle    = (state == ST_IDLE);
  assign take_load  = in_idle & req_load;
  assign take_clear = in_idle & ~req_load & req_clear;
  assign take_swap  = in_idle & ~req_load & ~req_clear & req_swap;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_load) begin
          state_nxt = ST_WRITE;
        end else if (take_clear) begin
          state_nxt = ST_CLEAR;
        end else if (take_swap) begin
          state_nxt = ST_SWAP_WAIT;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
`ifdef PHASE_CENTER_CLEAR_EN
      ST_CLEAR: begin
        if (clr_last) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      ST_SWAP_WAIT: begin
        if (sof) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // All writes land in the shadow bank, i.e. the one the datapath is not reading.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {~active_bank, cfg_data[NCH_W-1:0]};
    ram_wdata = cfg_data[16 +: CW];
    load_inc  = 1'b0;
    swap_now  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_WRITE: begin
        ram_we   = 1'b1;
        load_inc = 1'b1;
      end
`ifdef PHASE_CENTER_CLEAR_EN
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = {~active_bank, clr_cnt};
        ram_wdata = '0;
        busy      = 1'b1;
      end
`endif
      ST_SWAP_WAIT: swap_now = sof;
      default: ;
    endcase
  end

  // Events during the one-cycle WRITE are kept; CLEAR keeps only swaps; SWAP_WAIT keeps none.
  always_comb begin
    pend_load_nxt  = pend_load;
    pend_clear_nxt = pend_clear;
    pend_swap_nxt  = pend_swap;
    drop_inc       = 2'd0;
    case (state)
      ST_IDLE: begin
        pend_load_nxt  = 1'b0;
        pend_clear_nxt = req_clear & ~take_clear;
        pend_swap_nxt  = req_swap & ~take_swap;
      end
      ST_WRITE: begin
        pend_load_nxt  = pend_load  | ev_load;
        pend_clear_nxt = pend_clear | ev_clear;
        pend_swap_nxt  = pend_swap  | ev_swap;
      end
      ST_CLEAR: begin
        pend_swap_nxt = pend_swap | ev_swap;
        drop_inc      = 2'(ev_load) + 2'(ev_clear);
      end
      ST_SWAP_WAIT: begin
        drop_inc = 2'(ev_load) + 2'(ev_clear) + 2'(ev_swap);
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      pend_load   <= 1'b0;
      pend_clear  <= 1'b0;
      pend_swap   <= 1'b0;
      drop_cnt    <= '0;
      load_cnt    <= '0;
      active_bank <= 1'b0;
    end else begin
      pend_load  <= pend_load_nxt;
      pend_clear <= pend_clear_nxt;
      pend_swap  <= pend_swap_nxt;
      drop_cnt   <= drop_add(drop_cnt, drop_inc);
      if (load_inc) begin
        load_cnt <= load_cnt + 1'b1;
      end
      if (swap_now) begin
        active_bank <= ~active_bank;
      end
    end
  end

  // The read issued alongside the swapping sof already targets the new bank.
  assign rd_bank = swap_now ? ~active_bank : active_bank;

  pctl_dpram #(
    .AW(NCH_W + 1),
    .DW(CW)
  ) u_ram (
    .clk   (user_clk),
    .we_a  (ram_we),
    .addr_a(ram_waddr),
    .din_a (ram_wdata),
    .addr_b({rd_bank, ch_idx}),
    .dout_b(ram_q)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      rd_valid     <= 1'b0;
      center_valid <= 1'b0;
      center_out   <= '0;
    end else begin
      rd_valid     <= ch_valid;
      center_valid <= rd_valid;
      if (rd_valid) begin
        center_out <= ram_q;
      end
    end
  end

  always_comb begin
    status                                  = '0;
    status[STAT_SWAP_PEND]                  = (state == ST_SWAP_WAIT) | pend_swap;
    status[STAT_ACTIVE_BANK]                = active_bank;
    status[STAT_BUSY]                       = busy;
    status[STAT_DROP_LSB +: STAT_DROP_W]    = drop_cnt;
    status[STAT_LOAD_LSB +: STAT_LOAD_W]    = load_cnt;
  end

endmodule
